// File: rtl/adder_bist.sv
// adder_bist
// Built-in self-test controller for a 32-bit adder. It generates
// pseudo-random operands with a Galois LFSR and drives them onto the adder
// inputs. After a settle window it checks the adder result against a
// full-width reference sum. A run stops at the first mismatch or after
// N_VECTORS good vectors. The operands and result of the first failing
// vector are kept for inspection.
//
// Parameters
//   N_VECTORS : vectors per run (1 .. 2^32-1)
//   SEED      : LFSR seed, a zero seed is promoted to 1
//   SETTLE    : cycles between operand update and comparison (>= 1)
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   start                 : launches a run from IDLE or DONE
//   dut_a, dut_b, dut_cin : registered stimulus to the adder under test
//   dut_sum, dut_cout     : result returned by the adder under test
//   busy, done, pass      : run status
//   vec_count             : vectors that matched in the current run
//   fail_a, fail_b, fail_cin, fail_sum, fail_cout : first failing vector
module adder_bist #(
  parameter logic [31:0] N_VECTORS = 32'd10000,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned SETTLE    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] dut_a,
  output logic [31:0] dut_b,
  output logic        dut_cin,
  input  logic [31:0] dut_sum,
  input  logic        dut_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] vec_count,
  output logic [31:0] fail_a,
  output logic [31:0] fail_b,
  output logic        fail_cin,
  output logic [31:0] fail_sum,
  output logic        fail_cout
);

  localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] POLY        = 32'h8020_0003;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SETTLING,
    CHECK,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] shadowA_q, shadowA_d;
  logic [31:0] shadowB_q, shadowB_d;
  logic [1:0]  genCnt_q, genCnt_d;
  logic [31:0] settleCnt_q, settleCnt_d;
  logic [31:0] dutA_q, dutA_d;
  logic [31:0] dutB_q, dutB_d;
  logic        dutCin_q, dutCin_d;
  logic [31:0] vecCount_q, vecCount_d;
  logic        pass_q, pass_d;
  logic [31:0] failA_q, failA_d;
  logic [31:0] failB_q, failB_d;
  logic        failCin_q, failCin_d;
  logic [31:0] failSum_q, failSum_d;
  logic        failCout_q, failCout_d;

  logic [31:0] lfsrNext;
  logic [32:0] refSum;
  logic [32:0] observed;
  logic [31:0] countInc;

  // Datapath helpers: the LFSR successor value, the 33-bit reference
  // sum of the operands currently held on the adder inputs, and the
  // adder's own 33-bit result to compare against.
  always_comb begin
    lfsrNext = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'd0);
    refSum   = {1'b0, dutA_q} + {1'b0, dutB_q} + {32'd0, dutCin_q};
    observed = {dut_cout, dut_sum};
    countInc = vecCount_q + 32'd1;
  end

  // Next-state and datapath update. Every register holds by default.
  // The operand shadows let A, B and Cin reach the adder on a single
  // edge, so the adder inputs never change during the settle and check
  // window.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    shadowA_d   = shadowA_q;
    shadowB_d   = shadowB_q;
    genCnt_d    = genCnt_q;
    settleCnt_d = settleCnt_q;
    dutA_d      = dutA_q;
    dutB_d      = dutB_q;
    dutCin_d    = dutCin_q;
    vecCount_d  = vecCount_q;
    pass_d      = pass_q;
    failA_d     = failA_q;
    failB_d     = failB_q;
    failCin_d   = failCin_q;
    failSum_d   = failSum_q;
    failCout_d  = failCout_q;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          lfsr_d     = SEED_EFF;
          vecCount_d = 32'd0;
          pass_d     = 1'b0;
          failA_d    = 32'd0;
          failB_d    = 32'd0;
          failCin_d  = 1'b0;
          failSum_d  = 32'd0;
          failCout_d = 1'b0;
          genCnt_d   = 2'd0;
          state_d    = GEN;
        end
      end
      GEN: begin
        busy   = 1'b1;
        lfsr_d = lfsrNext;
        case (genCnt_q)
          2'd0: begin
            shadowA_d = lfsrNext;
            genCnt_d  = 2'd1;
          end
          2'd1: begin
            shadowB_d = lfsrNext;
            genCnt_d  = 2'd2;
          end
          default: begin
            dutA_d      = shadowA_q;
            dutB_d      = shadowB_q;
            dutCin_d    = lfsrNext[0];
            genCnt_d    = 2'd0;
            settleCnt_d = 32'd0;
            state_d     = SETTLING;
          end
        endcase
      end
      SETTLING: begin
        busy = 1'b1;
        if (settleCnt_q == SETTLE_LAST) begin
          state_d = CHECK;
        end else begin
          settleCnt_d = settleCnt_q + 32'd1;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (observed == refSum) begin
          vecCount_d = countInc;
          if (countInc == N_VECTORS) begin
            pass_d  = 1'b1;
            state_d = DONE;
          end else begin
            genCnt_d = 2'd0;
            state_d  = GEN;
          end
        end else begin
          failA_d    = dutA_q;
          failB_d    = dutB_q;
          failCin_d  = dutCin_q;
          failSum_d  = dut_sum;
          failCout_d = dut_cout;
          pass_d     = 1'b0;
          state_d    = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything and returns every
  // output to zero while reloading the LFSR with the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      shadowA_q   <= 32'd0;
      shadowB_q   <= 32'd0;
      genCnt_q    <= 2'd0;
      settleCnt_q <= 32'd0;
      dutA_q      <= 32'd0;
      dutB_q      <= 32'd0;
      dutCin_q    <= 1'b0;
      vecCount_q  <= 32'd0;
      pass_q      <= 1'b0;
      failA_q     <= 32'd0;
      failB_q     <= 32'd0;
      failCin_q   <= 1'b0;
      failSum_q   <= 32'd0;
      failCout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      shadowA_q   <= shadowA_d;
      shadowB_q   <= shadowB_d;
      genCnt_q    <= genCnt_d;
      settleCnt_q <= settleCnt_d;
      dutA_q      <= dutA_d;
      dutB_q      <= dutB_d;
      dutCin_q    <= dutCin_d;
      vecCount_q  <= vecCount_d;
      pass_q      <= pass_d;
      failA_q     <= failA_d;
      failB_q     <= failB_d;
      failCin_q   <= failCin_d;
      failSum_q   <= failSum_d;
      failCout_q  <= failCout_d;
    end
  end

  assign dut_a     = dutA_q;
  assign dut_b     = dutB_q;
  assign dut_cin   = dutCin_q;
  assign pass      = pass_q;
  assign vec_count = vecCount_q;
  assign fail_a    = failA_q;
  assign fail_b    = failB_q;
  assign fail_cin  = failCin_q;
  assign fail_sum  = failSum_q;
  assign fail_cout = failCout_q;

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist
// Scoreboard bench for adder_bist. The bench models the adder under test,
// with optional injected faults. A reference model predicts the operand
// stream and the outcome of each run from the LFSR rule and plain
// arithmetic. A monitor pops the predictions whenever the BIST applies
// new operands or raises done.
module tb_adder_bist;

  localparam logic [31:0] NV   = 32'd4;
  localparam int unsigned ST   = 4;
  localparam int unsigned VCYC = ST + 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start0;
  logic [31:0] dutA, dutB, dutSum, vecCount, failA, failB, failSum;
  logic        dutCin, dutCout, busy, done, pass, failCin, failCout;
  logic [31:0] dutA0, dutB0, dutSum0, vecCount0, failA0, failB0, failSum0;
  logic        dutCin0, dutCout0, busy0, done0, pass0, failCin0, failCout0;

  int unsigned cyc = 0;
  int unsigned vectorsApplied = 0;
  int unsigned miscompares = 0;
  int          faultType = 0;
  logic [31:0] faultA = 32'd0;
  logic [32:0] trueRes;

  typedef struct packed {
    logic [31:0] startCyc;
    logic [31:0] doneCyc;
    logic        pass;
    logic [31:0] cnt;
    logic [31:0] fa;
    logic [31:0] fb;
    logic        fcin;
    logic [31:0] fsum;
    logic        fcout;
  } result_t;

  result_t     expQ[$];
  logic [64:0] vecQ[$];

  adder_bist #(.N_VECTORS(NV), .SEED(32'h0000_0001), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dutA), .dut_b(dutB), .dut_cin(dutCin),
    .dut_sum(dutSum), .dut_cout(dutCout),
    .busy(busy), .done(done), .pass(pass), .vec_count(vecCount),
    .fail_a(failA), .fail_b(failB), .fail_cin(failCin),
    .fail_sum(failSum), .fail_cout(failCout)
  );

  adder_bist #(.N_VECTORS(32'd1), .SEED(32'h0000_0000), .SETTLE(1)) dutSeed0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(dutA0), .dut_b(dutB0), .dut_cin(dutCin0),
    .dut_sum(dutSum0), .dut_cout(dutCout0),
    .busy(busy0), .done(done0), .pass(pass0), .vec_count(vecCount0),
    .fail_a(failA0), .fail_b(failB0), .fail_cin(failCin0),
    .fail_sum(failSum0), .fail_cout(failCout0)
  );

  // Free-running clock and a cycle counter used to time done against E0.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test. Fault 1 flips sum bit 0 for one chosen operand A,
  // fault 2 holds carry-out at zero.
  always_comb begin
    trueRes = {1'b0, dutA} + {1'b0, dutB} + {32'd0, dutCin};
    dutSum  = trueRes[31:0];
    dutCout = trueRes[32];
    if (faultType == 1 && dutA == faultA) dutSum[0] = ~trueRes[0];
    if (faultType == 2) dutCout = 1'b0;
  end

  // The seed-zero instance gets a fault-free adder.
  assign {dutCout0, dutSum0} = {1'b0, dutA0} + {1'b0, dutB0} + {32'd0, dutCin0};

  function automatic logic [31:0] lfsrStep(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Operands of vector k from seed 1. Each vector uses three LFSR steps.
  function automatic logic [64:0] vectorAt(input int unsigned k);
    logic [31:0] l, a, b;
    logic        c;
    l = 32'h1; a = '0; b = '0; c = 1'b0;
    for (int unsigned i = 0; i <= k; i++) begin
      l = lfsrStep(l); a = l;
      l = lfsrStep(l); b = l;
      l = lfsrStep(l); c = l[0];
    end
    return {a, b, c};
  endfunction

  task automatic reportFail(input string name, input logic [64:0] act, input logic [64:0] exp);
    vectorsApplied++;
    miscompares++;
    $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of one run: walk the vectors, apply the adder's
  // fault to the true 33-bit sum and stop at the first difference.
  task automatic expectRun(input int unsigned e0);
    result_t     r;
    logic [64:0] v;
    logic [32:0] good, seen;
    r = '0;
    r.startCyc = e0;
    r.pass = 1'b1;
    r.doneCyc = e0 + NV * VCYC;
    for (int unsigned i = 0; i < NV; i++) begin
      v = vectorAt(i);
      vecQ.push_back(v);
      good = {1'b0, v[64:33]} + {1'b0, v[32:1]} + {32'd0, v[0]};
      seen = good;
      if (faultType == 1 && v[64:33] == faultA) seen[0] = ~seen[0];
      if (faultType == 2) seen[32] = 1'b0;
      if (seen != good) begin
        r.pass = 1'b0;
        r.cnt = i;
        r.fa = v[64:33];
        r.fb = v[32:1];
        r.fcin = v[0];
        r.fsum = seen[31:0];
        r.fcout = seen[32];
        r.doneCyc = e0 + (i + 1) * VCYC;
        break;
      end
      r.cnt = i + 1;
    end
    expQ.push_back(r);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    expectRun(cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitRunDone();
    for (int i = 0; i < 400; i++) begin
      if (expQ.size() == 0) return;
      @(negedge clk);
    end
    reportFail("run_timeout", 65'(expQ.size()), 65'd0);
    expQ.delete();
    vecQ.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    expQ.delete();
    vecQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ops"}, {dutA, dutB, dutCin}, 65'd0);
    checkOutput({tag, "_status"}, 65'({busy, done, pass}), 65'd0);
    checkOutput({tag, "_vec_count"}, 65'(vecCount), 65'd0);
    checkOutput({tag, "_fail_ops"}, {failA, failB, failCin}, 65'd0);
    checkOutput({tag, "_fail_res"}, 65'({failCout, failSum}), 65'd0);
  endtask

  // Monitor: compares every new operand set and every done rising edge
  // against the head of the scoreboard queues, and notes whether busy
  // ever dropped while a run was in flight.
  initial begin
    logic [64:0] prevOps;
    logic [64:0] ops;
    logic [64:0] ev;
    logic        prevDone;
    logic        busyGap;
    result_t     r;
    prevOps = '0;
    prevDone = 1'b0;
    busyGap = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ops = {dutA, dutB, dutCin};
      if (rst) begin
        prevOps = ops;
        prevDone = 1'b0;
        busyGap = 1'b0;
        continue;
      end
      if (ops != prevOps) begin
        if (vecQ.size() == 0) begin
          reportFail("unexpected_vector", ops, 65'd0);
        end else begin
          ev = vecQ.pop_front();
          checkOutput("vector_ops", ops, ev);
        end
      end
      if (expQ.size() > 0 && cyc >= expQ[0].startCyc && cyc < expQ[0].doneCyc && !busy)
        busyGap = 1'b1;
      if (done && !prevDone) begin
        if (expQ.size() == 0) begin
          reportFail("unexpected_done", 65'(cyc), 65'd0);
        end else begin
          r = expQ.pop_front();
          checkOutput("done_cycle", 65'(cyc), 65'(r.doneCyc));
          checkOutput("pass", 65'(pass), 65'(r.pass));
          checkOutput("vec_count", 65'(vecCount), 65'(r.cnt));
          checkOutput("fail_ops", {failA, failB, failCin}, {r.fa, r.fb, r.fcin});
          checkOutput("fail_result", 65'({failCout, failSum}), 65'({r.fcout, r.fsum}));
          checkOutput("busy_at_done", 65'(busy), 65'd0);
          checkOutput("busy_held", 65'(busyGap), 65'd0);
        end
        busyGap = 1'b0;
      end
      prevDone = done;
      prevOps = ops;
    end
  end

  // Watchdog so the bench always ends even if the DUT stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomised fault runs.
  initial begin
    logic [64:0] v;
    int unsigned k;
    int unsigned waitCnt;
    rst = 1'b1;
    start = 1'b0;
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    $display("[TB] passing run with a stray start while busy");
    faultType = 0;
    applyStimulus();
    repeat ($urandom_range(1, 25)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitRunDone();
    checkOutput("pass_run_done", 65'({done, pass}), 65'b11);
    checkOutput("pass_run_count", 65'(vecCount), 65'd4);

    $display("[TB] restart from DONE");
    applyStimulus();
    checkOutput("restart_cleared", 65'({busy, done, pass}), 65'b100);
    checkOutput("restart_count", 65'(vecCount), 65'd0);
    waitRunDone();

    $display("[TB] sum bit 0 fault on vector 0");
    doReset();
    faultType = 1;
    faultA = 32'h8020_0003;
    applyStimulus();
    waitRunDone();
    checkOutput("sum_fault_fail_sum", 65'({failCout, failSum}), 65'({1'b1, 32'h4050_0007}));
    checkOutput("sum_fault_fail_ops", {failA, failB, failCin}, {32'h8020_0003, 32'hC030_0002, 1'b1});

    $display("[TB] carry-out stuck at zero");
    doReset();
    faultType = 2;
    applyStimulus();
    waitRunDone();
    checkOutput("stuck_cout", 65'({pass, failCout, vecCount}), 65'd0);

    $display("[TB] randomised fault runs");
    for (int t = 0; t < 6; t++) begin
      doReset();
      faultType = int'($urandom_range(0, 2));
      k = $urandom_range(0, 4);
      v = vectorAt(k);
      faultA = (k < 4) ? v[64:33] : 32'hFFFF_FFFF;
      applyStimulus();
      waitRunDone();
    end

    $display("[TB] reset during settle of vector 2");
    doReset();
    faultType = 0;
    applyStimulus();
    repeat (2 * VCYC + 4) @(negedge clk);
    rst = 1'b1;
    expQ.delete();
    vecQ.delete();
    @(negedge clk);
    checkAllZero("abort");
    rst = 1'b0;
    applyStimulus();
    waitRunDone();

    $display("[TB] start held high through DONE");
    doReset();
    @(negedge clk);
    expectRun(cyc + 1);
    expectRun(cyc + 1 + NV * VCYC + 1);
    start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    waitRunDone();

    $display("[TB] zero seed instance");
    doReset();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    waitCnt = 0;
    while (!done0 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!done0) reportFail("seed0_timeout", 65'(waitCnt), 65'd0);
    checkOutput("seed0_ops", {dutA0, dutB0, dutCin0}, {32'h8020_0003, 32'hC030_0002, 1'b1});
    checkOutput("seed0_pass", 65'({pass0, vecCount0}), 65'({1'b1, 32'd1}));

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
